// File: rtl/hms_time_counter.sv
// rtl/hms_time_counter.sv - hh:mm:ss up/down time counter driven by a one-second tick
// Keeps binary time fields, exposes them as BCD and pulses on day wrap / countdown expiry.
module hms_time_counter #(
  parameter int unsigned HOUR_MAX = 23
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_bps,
  input  logic        start,
  input  logic        stop,
  input  logic        load,
  input  logic [4:0]  load_h,
  input  logic [5:0]  load_m,
  input  logic [5:0]  load_s,
  input  logic        dir_down,
  output logic [4:0]  hour,
  output logic [5:0]  min,
  output logic [5:0]  sec,
  output logic [23:0] bcd,
  output logic        running,
  output logic        expire,
  output logic        day_wrap
);

  localparam logic [4:0] HMAX = 5'(HOUR_MAX);

  typedef enum logic [1:0] {
    ST_STOP,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t     state_q, state_d;
  logic       dir_q, dir_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       expire_q, expire_d;
  logic       day_wrap_q, day_wrap_d;
  logic       time_zero;

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [5:0] tens;
    logic [5:0] ones;
    tens = v / 6'd10;
    ones = v % 6'd10;
    return {tens[3:0], ones[3:0]};
  endfunction

  assign time_zero = (hour_q == 5'd0) && (min_q == 6'd0) && (sec_q == 6'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_STOP;
      dir_q      <= 1'b0;
      hour_q     <= 5'd0;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      expire_q   <= 1'b0;
      day_wrap_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      expire_q   <= expire_d;
      day_wrap_q <= day_wrap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    expire_d   = 1'b0;
    day_wrap_d = 1'b0;

    if (load) begin
      state_d = ST_STOP;
      hour_d  = (load_h > HMAX)  ? HMAX  : load_h;
      min_d   = (load_m > 6'd59) ? 6'd59 : load_m;
      sec_d   = (load_s > 6'd59) ? 6'd59 : load_s;
    end else begin
      case (state_q)
        ST_STOP: begin
          if (start && !stop) begin
            dir_d = dir_down;
            // A countdown from zero has nothing to count, so it expires right away.
            if (dir_down && time_zero) begin
              state_d  = ST_DONE;
              expire_d = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_STOP;
          end else if (clk_bps) begin
            if (!dir_q) begin
              if (sec_q != 6'd59) begin
                sec_d = sec_q + 6'd1;
              end else begin
                sec_d = 6'd0;
                if (min_q != 6'd59) begin
                  min_d = min_q + 6'd1;
                end else begin
                  min_d = 6'd0;
                  if (hour_q != HMAX) begin
                    hour_d = hour_q + 5'd1;
                  end else begin
                    hour_d     = 5'd0;
                    day_wrap_d = 1'b1;
                  end
                end
              end
            end else begin
              if ((hour_q == 5'd0) && (min_q == 6'd0) && (sec_q <= 6'd1)) begin
                sec_d    = 6'd0;
                state_d  = ST_DONE;
                expire_d = 1'b1;
              end else if (sec_q != 6'd0) begin
                sec_d = sec_q - 6'd1;
              end else begin
                sec_d = 6'd59;
                if (min_q != 6'd0) begin
                  min_d = min_q - 6'd1;
                end else begin
                  min_d  = 6'd59;
                  hour_d = hour_q - 5'd1;
                end
              end
            end
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_STOP;
        end
      endcase
    end
  end

  assign hour     = hour_q;
  assign min      = min_q;
  assign sec      = sec_q;
  assign bcd      = {to_bcd({1'b0, hour_q}), to_bcd(min_q), to_bcd(sec_q)};
  assign running  = (state_q == ST_RUN);
  assign expire   = expire_q;
  assign day_wrap = day_wrap_q;

endmodule

// File: tb/tb_hms_time_counter.sv
// tb/tb_hms_time_counter.sv - scoreboard bench for hms_time_counter
// Stimulus queues the expected outputs per cycle; a negedge monitor pops and compares them.
module tb_hms_time_counter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_bps, start, stop, load, dir_down;
  logic [4:0]  load_h;
  logic [5:0]  load_m, load_s;
  logic [4:0]  hour;
  logic [5:0]  min, sec;
  logic [23:0] bcd;
  logic        running, expire, day_wrap;

  typedef struct {
    int          cyc;
    int          tag;
    logic [4:0]  h;
    logic [5:0]  m;
    logic [5:0]  s;
    logic [23:0] bcd;
    logic        chk_bcd;
    logic        run;
    logic        exp;
    logic        dw;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc_cnt = 0;
  int   tag_cnt = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;

  hms_time_counter #(.HOUR_MAX(23)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_bps  (clk_bps),
    .start    (start),
    .stop     (stop),
    .load     (load),
    .load_h   (load_h),
    .load_m   (load_m),
    .load_s   (load_s),
    .dir_down (dir_down),
    .hour     (hour),
    .min      (min),
    .sec      (sec),
    .bcd      (bcd),
    .running  (running),
    .expire   (expire),
    .day_wrap (day_wrap)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      if (q[0].cyc < cyc_cnt) begin
        mon_e = q.pop_front();
        n_chk++;
        n_fail++;
        $display("FAIL step%0d missed: due cycle %0d, now %0d", mon_e.tag, mon_e.cyc, cyc_cnt);
      end else if (q[0].cyc == cyc_cnt) begin
        mon_e = q.pop_front();
        n_chk++;
        if (hour !== mon_e.h || min !== mon_e.m || sec !== mon_e.s ||
            running !== mon_e.run || expire !== mon_e.exp || day_wrap !== mon_e.dw ||
            (mon_e.chk_bcd && bcd !== mon_e.bcd)) begin
          n_fail++;
          $display("FAIL step%0d: got %0d:%0d:%0d bcd=%h run=%b exp=%b dw=%b, want %0d:%0d:%0d bcd=%h run=%b exp=%b dw=%b",
                   mon_e.tag, hour, min, sec, bcd, running, expire, day_wrap,
                   mon_e.h, mon_e.m, mon_e.s, mon_e.bcd, mon_e.run, mon_e.exp, mon_e.dw);
        end
      end
    end
  end

  // Inputs are set by the caller; the expectation applies after the next posedge.
  task automatic step(input logic [4:0] eh, input logic [5:0] em, input logic [5:0] es,
                      input logic [23:0] ebcd, input logic cb,
                      input logic er, input logic ee, input logic ed);
    exp_t e;
    e.cyc     = cyc_cnt + 1;
    e.tag     = tag_cnt;
    e.h       = eh;
    e.m       = em;
    e.s       = es;
    e.bcd     = ebcd;
    e.chk_bcd = cb;
    e.run     = er;
    e.exp     = ee;
    e.dw      = ed;
    q.push_back(e);
    tag_cnt++;
    @(posedge clk);
    #1;
    start   = 1'b0;
    stop    = 1'b0;
    load    = 1'b0;
    clk_bps = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    load   = 1'b1;
    load_h = h;
    load_m = m;
    load_s = s;
  endtask

  task automatic check_zero(input string name);
    n_chk++;
    if (hour !== 5'd0 || min !== 6'd0 || sec !== 6'd0 || bcd !== 24'h0 ||
        running !== 1'b0 || expire !== 1'b0 || day_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got %0d:%0d:%0d bcd=%h run=%b exp=%b dw=%b, want all zero",
               name, hour, min, sec, bcd, running, expire, day_wrap);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clk_bps = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
    dir_down = 1'b0; load_h = 5'd0; load_m = 6'd0; load_s = 6'd0;
    #3;
    check_zero("reset_initial");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(0, 0, 0, 24'h000000, 1, 0, 0, 0);

    // clamp and BCD
    set_load(5'd31, 6'd63, 6'd60); step(23, 59, 59, 24'h235959, 1, 0, 0, 0);
    set_load(5'd12, 6'd34, 6'd56); step(12, 34, 56, 24'h123456, 1, 0, 0, 0);

    // up-count day wrap
    set_load(5'd23, 6'd59, 6'd58); step(23, 59, 58, 24'h235958, 1, 0, 0, 0);
    start = 1'b1;                  step(23, 59, 58, 24'h235958, 1, 1, 0, 0);
    clk_bps = 1'b1;                step(23, 59, 59, 24'h235959, 1, 1, 0, 0);
    clk_bps = 1'b1;                step(0, 0, 0, 24'h000000, 1, 1, 0, 1);
                                   step(0, 0, 0, 24'h000000, 1, 1, 0, 0);
    stop = 1'b1;                   step(0, 0, 0, 24'h000000, 1, 0, 0, 0);

    // start-tick coincidence, dir change while running, pause
    set_load(5'd1, 6'd2, 6'd3);    step(1, 2, 3, 24'h010203, 1, 0, 0, 0);
    start = 1'b1; clk_bps = 1'b1;  step(1, 2, 3, 24'h010203, 1, 1, 0, 0);
    clk_bps = 1'b1;                step(1, 2, 4, 24'h010204, 1, 1, 0, 0);
    dir_down = 1'b1; clk_bps = 1'b1; step(1, 2, 5, 24'h010205, 1, 1, 0, 0);
    dir_down = 1'b0;
    stop = 1'b1;                   step(1, 2, 5, 24'h010205, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      clk_bps = 1'b1;              step(1, 2, 5, 24'h010205, 1, 0, 0, 0);
    end
    start = 1'b1;                  step(1, 2, 5, 24'h010205, 1, 1, 0, 0);
    clk_bps = 1'b1;                step(1, 2, 6, 24'h010206, 1, 1, 0, 0);

    // priority
    stop = 1'b1;                   step(1, 2, 6, 24'h010206, 1, 0, 0, 0);
    start = 1'b1; stop = 1'b1;     step(1, 2, 6, 24'h010206, 1, 0, 0, 0);
    start = 1'b1;                  step(1, 2, 6, 24'h010206, 1, 1, 0, 0);
    stop = 1'b1; clk_bps = 1'b1;   step(1, 2, 6, 24'h010206, 1, 0, 0, 0);
    start = 1'b1;                  step(1, 2, 6, 24'h010206, 1, 1, 0, 0);
    set_load(5'd10, 6'd20, 6'd30); clk_bps = 1'b1; start = 1'b1;
                                   step(10, 20, 30, 24'h102030, 1, 0, 0, 0);
    clk_bps = 1'b1;                step(10, 20, 30, 24'h102030, 1, 0, 0, 0);

    // countdown 00:01:01 -> expire on tick 61
    set_load(5'd0, 6'd1, 6'd1);    step(0, 1, 1, 24'h000101, 1, 0, 0, 0);
    dir_down = 1'b1; start = 1'b1; step(0, 1, 1, 24'h000101, 1, 1, 0, 0);
    for (int k = 1; k <= 62; k++) begin
      int rem;
      rem = (k <= 61) ? (61 - k) : 0;
      clk_bps = 1'b1;
      step(5'd0, 6'(rem / 60), 6'(rem % 60), 24'h0, 0, (k < 61), (k == 61), 1'b0);
    end
    start = 1'b1;                  step(0, 0, 0, 24'h000000, 1, 0, 0, 0);

    // leave DONE by load; down-start at zero expires without a tick
    set_load(5'd0, 6'd0, 6'd0);    step(0, 0, 0, 24'h000000, 1, 0, 0, 0);
    start = 1'b1;                  step(0, 0, 0, 24'h000000, 1, 0, 1, 0);
                                   step(0, 0, 0, 24'h000000, 1, 0, 0, 0);
    set_load(5'd0, 6'd0, 6'd5);    step(0, 0, 5, 24'h000005, 1, 0, 0, 0);
    start = 1'b1;                  step(0, 0, 5, 24'h000005, 1, 1, 0, 0);
    clk_bps = 1'b1;                step(0, 0, 4, 24'h000004, 1, 1, 0, 0);

    // async reset while running
    set_load(5'd5, 6'd6, 6'd7);    step(5, 6, 7, 24'h050607, 1, 0, 0, 0);
    dir_down = 1'b0; start = 1'b1; step(5, 6, 7, 24'h050607, 1, 1, 0, 0);
    clk_bps = 1'b1;                step(5, 6, 8, 24'h050608, 1, 1, 0, 0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_zero("reset_async");
    @(posedge clk); #1;
    check_zero("reset_held");
    rst_n = 1'b1;
                                   step(0, 0, 0, 24'h000000, 1, 0, 0, 0);
    clk_bps = 1'b1;                step(0, 0, 0, 24'h000000, 1, 0, 0, 0);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
